// File: rtl/mtf4_if.sv
// Symbol-in / byte-out handshake bundle for the MTF-4 decoder.
// The master side belongs to the symbol source, which also drives the
// byte sink's out_ready. The slave side belongs to the decoder.
interface mtf4_if #(
    parameter int W = 8
);
    logic         sym_valid;
    logic         sym_ready;
    logic         sym_is_lit;
    logic [W-1:0] sym_lit;
    logic [1:0]   sym_idx;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output sym_valid, sym_is_lit, sym_lit, sym_idx, out_ready,
        input  sym_ready, out_valid, out_data
    );

    modport slave (
        input  sym_valid, sym_is_lit, sym_lit, sym_idx, out_ready,
        output sym_ready, out_valid, out_data
    );
endinterface

// File: rtl/mtf4_decoder.sv
// Move-to-front decoder for a 4-entry MRU byte table.
// Literal symbols push a new byte in at the front of the table. Index
// symbols pull an existing entry to the front. A literal that is already
// in the table is handled as a pull of that entry to the front.
// There is a single registered output stage with no skid buffer.
module mtf4_decoder #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    mtf4_if.slave            s,
    output logic [W-1:0]     tbl_0,
    output logic [W-1:0]     tbl_1,
    output logic [W-1:0]     tbl_2,
    output logic [W-1:0]     tbl_3,
    output logic [3:0]       tbl_valid,
    output logic             err_bad_idx,
    output logic [CNT_W-1:0] lit_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [W-1:0] tbl_q   [4];
    logic [W-1:0] nxt_tbl [4];
    logic [3:0]   vld_q;
    logic [3:0]   nxt_vld;

    logic         vld_p1;
    logic [W-1:0] out_data_p1;

    logic         accept;
    logic [3:0]   match;
    logic         lit_hit;
    logic [1:0]   hit_pos;
    logic         idx_ok;
    logic [1:0]   mtf_pos;
    logic         do_push;
    logic         do_mtf;
    logic         emit;
    logic [W-1:0] emit_data;

    // Increment that stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign s.sym_ready = !rst && (!vld_p1 || s.out_ready);
    assign accept      = s.sym_valid && s.sym_ready;

    // Only valid entries can match a literal, so stale zeros never alias a literal 0.
    assign match = {vld_q[3] && (tbl_q[3] == s.sym_lit),
                    vld_q[2] && (tbl_q[2] == s.sym_lit),
                    vld_q[1] && (tbl_q[1] == s.sym_lit),
                    vld_q[0] && (tbl_q[0] == s.sym_lit)};

    // Classify the offered symbol and pick the entry to bring to the front.
    always_comb begin
        lit_hit   = |match;
        hit_pos   = 2'd0;
        if (match[0])      hit_pos = 2'd0;
        else if (match[1]) hit_pos = 2'd1;
        else if (match[2]) hit_pos = 2'd2;
        else if (match[3]) hit_pos = 2'd3;
        idx_ok    = vld_q[s.sym_idx];
        mtf_pos   = s.sym_is_lit ? hit_pos : s.sym_idx;
        do_push   = s.sym_is_lit && !lit_hit;
        do_mtf    = s.sym_is_lit ? lit_hit : idx_ok;
        emit      = s.sym_is_lit || idx_ok;
        emit_data = s.sym_is_lit ? s.sym_lit : tbl_q[s.sym_idx];
    end

    // Next table contents: push-front for new literals, rotate-to-front for hits.
    always_comb begin
        nxt_tbl = tbl_q;
        nxt_vld = vld_q;
        if (accept && do_push) begin
            nxt_tbl[3] = tbl_q[2];
            nxt_tbl[2] = tbl_q[1];
            nxt_tbl[1] = tbl_q[0];
            nxt_tbl[0] = s.sym_lit;
            nxt_vld    = {vld_q[2:0], 1'b1};
        end else if (accept && do_mtf) begin
            nxt_tbl[0] = tbl_q[mtf_pos];
            if (mtf_pos >= 2'd1) nxt_tbl[1] = tbl_q[0];
            if (mtf_pos >= 2'd2) nxt_tbl[2] = tbl_q[1];
            if (mtf_pos == 2'd3) nxt_tbl[3] = tbl_q[2];
        end
    end

    // Table state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) tbl_q[k] <= '0;
            vld_q <= 4'b0000;
        end else begin
            tbl_q <= nxt_tbl;
            vld_q <= nxt_vld;
        end
    end

    // Stage p1: output byte register, loaded only when a symbol is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
        end else if (accept) begin
            vld_p1 <= emit;
            if (emit) out_data_p1 <= emit_data;
        end else if (s.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Sticky error flag and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_bad_idx <= 1'b0;
            lit_cnt     <= '0;
            hit_cnt     <= '0;
        end else if (accept) begin
            if (s.sym_is_lit)  lit_cnt     <= sat_inc(lit_cnt);
            else if (idx_ok)   hit_cnt     <= sat_inc(hit_cnt);
            else               err_bad_idx <= 1'b1;
        end
    end

    assign s.out_valid = vld_p1;
    assign s.out_data  = out_data_p1;
    assign tbl_0       = tbl_q[0];
    assign tbl_1       = tbl_q[1];
    assign tbl_2       = tbl_q[2];
    assign tbl_3       = tbl_q[3];
    assign tbl_valid   = vld_q;

endmodule

// File: tb/tb_mtf4_decoder.sv
// Bench for mtf4_decoder: directed symbols, expected bytes queued at
// acceptance and compared by an independent output monitor.
module tb_mtf4_decoder;
    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [W-1:0]     tbl_0, tbl_1, tbl_2, tbl_3;
    logic [3:0]       tbl_valid;
    logic             err_bad_idx;
    logic [CNT_W-1:0] lit_cnt, hit_cnt;

    mtf4_if #(.W(W)) bus ();

    mtf4_decoder #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (bus.slave),
        .tbl_0       (tbl_0),
        .tbl_1       (tbl_1),
        .tbl_2       (tbl_2),
        .tbl_3       (tbl_3),
        .tbl_valid   (tbl_valid),
        .err_bad_idx (err_bad_idx),
        .lit_cnt     (lit_cnt),
        .hit_cnt     (hit_cnt)
    );

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every byte the sink takes must be the next queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got 0x%0h expected no output", bus.out_data);
            end else begin
                check("out_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Offer one symbol and hold it until accepted; queue its expected byte.
    task automatic send(input logic is_lit, input logic [7:0] v, input logic [1:0] idx,
                        input logic has_out, input logic [7:0] exp);
        bit done = 0;
        bus.sym_valid  = 1'b1;
        bus.sym_is_lit = is_lit;
        bus.sym_lit    = v;
        bus.sym_idx    = idx;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (bus.sym_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        bus.sym_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: got not accepted expected accepted");
        end else if (has_out) begin
            exp_q.push_back(exp);
        end
    endtask

    task automatic lit(input logic [7:0] v);
        send(1'b1, v, 2'd0, 1'b1, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sym_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("sym_ready_in_rst", {31'd0, bus.sym_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_out_data"}, {24'd0, bus.out_data}, 32'd0);
        check({tag, "_tbl"}, {tbl_0, tbl_1, tbl_2, tbl_3}, 32'd0);
        check({tag, "_tbl_valid"}, {28'd0, tbl_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, err_bad_idx}, 32'd0);
        check({tag, "_lit_cnt"}, {16'd0, lit_cnt}, 32'd0);
        check({tag, "_hit_cnt"}, {16'd0, hit_cnt}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.sym_valid  = 1'b0;
        bus.sym_is_lit = 1'b0;
        bus.sym_lit    = '0;
        bus.sym_idx    = 2'd0;
        bus.out_ready  = 1'b1;
        do_reset();
        check_zero_state("reset");

        // Fill the table with five literals; 0x11 is evicted.
        lit(8'h11);
        check("first_latency_valid", {31'd0, bus.out_valid}, 32'd1);
        check("first_latency_data", {24'd0, bus.out_data}, 32'h11);
        lit(8'h22); lit(8'h33); lit(8'h44); lit(8'h55);
        idle(2);
        check("fill_tbl", {tbl_0, tbl_1, tbl_2, tbl_3}, 32'h55443322);
        check("fill_valid", {28'd0, tbl_valid}, 32'hF);
        check("fill_lit_cnt", {16'd0, lit_cnt}, 32'd5);

        // Index hits: 2, 3, 0.
        send(1'b0, 8'h00, 2'd2, 1'b1, 8'h33);
        check("idx2_tbl", {tbl_0, tbl_1, tbl_2, tbl_3}, 32'h33554422);
        send(1'b0, 8'h00, 2'd3, 1'b1, 8'h22);
        check("idx3_tbl", {tbl_0, tbl_1, tbl_2, tbl_3}, 32'h22335544);
        send(1'b0, 8'h00, 2'd0, 1'b1, 8'h22);
        check("idx0_tbl", {tbl_0, tbl_1, tbl_2, tbl_3}, 32'h22335544);
        check("idx_hit_cnt", {16'd0, hit_cnt}, 32'd3);
        check("idx_valid", {28'd0, tbl_valid}, 32'hF);
        idle(2);

        // Non-canonical literal matching entry 2.
        do_reset();
        lit(8'h11); lit(8'h22); lit(8'h33); lit(8'h44);
        lit(8'h22);
        check("noncanon_tbl", {tbl_0, tbl_1, tbl_2, tbl_3}, 32'h22443311);
        check("noncanon_lit_cnt", {16'd0, lit_cnt}, 32'd5);
        check("noncanon_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        check("noncanon_valid", {28'd0, tbl_valid}, 32'hF);
        idle(2);

        // Literal 0 into an empty table, then an index to an invalid entry.
        do_reset();
        lit(8'h00);
        check("lit0_valid", {28'd0, tbl_valid}, 32'h1);
        send(1'b0, 8'h00, 2'd1, 1'b0, 8'h00);
        check("badidx_err", {31'd0, err_bad_idx}, 32'd1);
        check("badidx_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("badidx_valid", {28'd0, tbl_valid}, 32'h1);
        check("badidx_tbl0", {24'd0, tbl_0}, 32'h00);
        check("badidx_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        idle(2);

        // Backpressure: A1 held, A2 stalled until the sink accepts.
        bus.out_ready = 1'b0;
        lit(8'hA1);
        bus.sym_valid  = 1'b1;
        bus.sym_is_lit = 1'b1;
        bus.sym_lit    = 8'hA2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
            check("bp_out_data", {24'd0, bus.out_data}, 32'hA1);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        check("bp_tbl0_before", {24'd0, tbl_0}, 32'hA1);
        bus.out_ready = 1'b1;
        lit(8'hA2);
        check("bp_a2_out", {24'd0, bus.out_data}, 32'hA2);
        idle(2);
        check("bp_tbl", {tbl_0, tbl_1, tbl_2}, 24'hA2A100);
        check("bp_lit_cnt", {16'd0, lit_cnt}, 32'd3);

        // Reset while a byte is stalled at the output.
        bus.out_ready = 1'b0;
        lit(8'h5A);
        idle(1);
        check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_state("midrst");
        bus.out_ready = 1'b1;
        lit(8'h77);
        check("resume_out", {24'd0, bus.out_data}, 32'h77);
        check("resume_tbl0", {24'd0, tbl_0}, 32'h77);
        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mtf4_decoder.md
Name: mtf4_decoder

Overview:
- Move-to-front decoder for the 4-entry most-recently-used (MRU) symbol stream; the receive-side counterpart of the last-unique-4 MRU tracker.
- Each input symbol is one of two kinds:
  - a literal byte, which enters the table at position 0;
  - a 2-bit index into the MRU table of the last 4 unique bytes.
- The block rebuilds the original byte stream and keeps an MRU table identical to the encoder's.
- Sits between the symbol unpacker (upstream) and the byte sink (downstream), with valid/ready on both sides.

Parameters:
- W, 8, data byte width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- sym_valid  in  1  input symbol valid.
- sym_ready  out  1  input symbol accepted when sym_valid && sym_ready.
- sym_is_lit  in  1  1 = literal symbol, 0 = index symbol.
- sym_lit  in  W  literal value; don't-care for an index symbol.
- sym_idx  in  2  MRU position; don't-care for a literal symbol.
- out_valid  out  1  decoded byte valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  W  decoded byte.
- tbl_0..tbl_3  out  W each  MRU table entries; tbl_0 is the most recent.
- tbl_valid  out  4  bit k = entry k valid.
- err_bad_idx  out  1  sticky: an index hit an invalid entry.
- lit_cnt  out  CNT_W  count of accepted literals, saturating.
- hit_cnt  out  CNT_W  count of accepted valid index symbols, saturating.

Behaviour:
- Reset:
  - Takes effect on the rising clk edge with rst=1.
  - out_valid=0, out_data=0, all tbl_k=0, tbl_valid=4'b0000, err_bad_idx=0, lit_cnt=0, hit_cnt=0.
  - Reset overrides any handshake in the same cycle; an in-flight output is dropped.
- Handshake:
  - sym_ready = !out_valid || out_ready (single output register, no skid).
  - sym_ready is 0 while rst=1.
  - out_data/out_valid hold stable while out_valid && !out_ready.
  - Latency: symbol accepted at edge N → byte appears on out_data/out_valid after edge N, so it is first sampleable at edge N+1.
  - Throughput: 1 symbol per cycle when out_ready=1.
- Valid bits: tbl_valid is always thermometer (valid entries contiguous from position 0).
- Literal L, no entry equal to L:
  - tbl_3<=tbl_2, tbl_2<=tbl_1, tbl_1<=tbl_0, tbl_0<=L.
  - tbl_valid <= {tbl_valid[2:0],1}.
  - Entry 3 is evicted when the table is full.
  - Emit L; lit_cnt+1.
- Literal L equal to a valid entry k (non-canonical encoder output):
  - Treated as a move-to-front of entry k, same as an index hit below.
  - Emit L; lit_cnt+1; hit_cnt unchanged.
- Index i with tbl_valid[i]=1:
  - Emit tbl_i.
  - Entries 0..i-1 shift down one position; entry i moves to position 0; entries above i are unchanged.
  - i=0 leaves the table unchanged. tbl_valid is unchanged.
  - hit_cnt+1.
- Index i with tbl_valid[i]=0:
  - Symbol is consumed; no byte is emitted (out_valid is cleared if the previous byte was taken, otherwise held).
  - Table is unchanged; err_bad_idx<=1 until reset.
- Emit/accept rule: a new output is loaded only on symbol acceptance. If out_valid && out_ready and no symbol is accepted, out_valid<=0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Comparison for the equality check uses valid entries only. An invalid entry holding 0 never matches a literal 0.
- Reference model: the table must track an encoder MRU state exactly for any canonical stream (literals only for values not in the table, indices only for valid entries).

Test Plan:
- Reset, out_ready=1, then literals 0x11,0x22,0x33,0x44,0x55 → outputs 11,22,33,44,55 one cycle after each accept; final table 55,44,33,22; tbl_valid=1111; lit_cnt=5.
- From that state, index 2 (0x33), then index 3 (0x22), then index 0 → outputs 33,22,22; table after index 2 is 33,55,44,22; after index 3 is 22,33,55,44; after index 0 unchanged; hit_cnt=3.
- After reset, literal 0x00 with empty table → accepted as a new entry (not matched against invalid zeros); tbl_valid=0001; then index 1 → no output, err_bad_idx=1, table unchanged.
- Backpressure: out_ready=0 with literals 0xA1,0xA2 offered back-to-back → 0xA1 held on out_data, sym_ready=0, 0xA2 not consumed; raise out_ready → 0xA1 taken, 0xA2 follows next cycle; nothing lost or duplicated.
- Non-canonical literal 0x22 while the table is 44,33,22,11 → output 22; table 22,44,33,11; lit_cnt+1; hit_cnt unchanged.
- Assert rst mid-stream while out_valid=1 and out_ready=0 → next cycle all outputs, table, counters and err_bad_idx are 0; stream resumes correctly with literal 0x77 → output 77.
